pressure_alarm_monitor: RTL
===========================

PRESSURE_ALARM_MONITOR -- requirements
Module: pressure_alarm_monitor

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent pressure channels.
REQ-002 SHALL have parameter DATA_WIDTH, default 6: width of one pressure sample.
REQ-003 SHALL have parameter LOW_TH, default 10: samples strictly below this are abnormal.
REQ-004 SHALL have parameter HIGH_TH, default 50: samples strictly above this are abnormal.
REQ-005 SHALL have parameter PERSIST, default 3, range 1..15: consecutive abnormal samples needed to raise an alarm.
REQ-006 SHALL have parameter CLEAR_COUNT, default 2, range 1..15: consecutive normal samples needed to leave ACKED.
REQ-007 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-008 SHALL have port rstN, input, 1: asynchronous active-low reset.
REQ-009 SHALL have port pressureData, input, CHANNELS*DATA_WIDTH: channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port sampleValid, input, 1: all channels sampled this cycle.
REQ-011 SHALL have port alarmAck, input, 1: single-cycle acknowledge strobe.
REQ-012 SHALL have port ackChannel, input, clog2(CHANNELS): channel targeted by alarmAck.
REQ-013 SHALL have port pressureAbnormality, output, CHANNELS: registered raw abnormality of the last valid sample.
REQ-014 SHALL have port alarmActive, output, CHANNELS: channel in ALARM or ACKED.
REQ-015 SHALL have port alarmIrq, output, 1: OR of channels in ALARM (unacknowledged).
REQ-016 SHALL have port alarmChannel, output, clog2(CHANNELS): lowest-index channel in ALARM; 0 when none.

Function
REQ-017 Sample SHALL be abnormal iff data < LOW_TH or data > HIGH_TH; values equal to either threshold are normal; comparison unsigned.
REQ-018 On sampleValid, pressureAbnormality SHALL update one cycle later; it SHALL hold its value while sampleValid is low.
REQ-019 Each channel SHALL run an independent FSM: NORMAL, SUSPECT, ALARM, ACKED, with a 4-bit saturating counter.
REQ-020 NORMAL: valid abnormal sample -> SUSPECT with count 1, or ALARM directly if PERSIST==1; valid normal -> stays.
REQ-021 SUSPECT: valid abnormal -> count+1, entering ALARM on the edge the PERSIST-th consecutive abnormal sample is captured; valid normal -> NORMAL, count 0.
REQ-022 ALARM: SHALL latch regardless of data; alarmAck with ackChannel equal to the channel -> ACKED, count 0.
REQ-023 ACKED: valid normal -> count+1, entering NORMAL on the CLEAR_COUNT-th consecutive normal; valid abnormal -> count 0, stays ACKED.
REQ-024 alarmAck targeting a channel not in ALARM SHALL be ignored; ackChannel >= CHANNELS SHALL be ignored.
REQ-025 If alarmAck and sampleValid coincide on an ALARM channel, the channel SHALL go to ACKED and that cycle's sample SHALL not count for it.
REQ-026 States SHALL not change in cycles with sampleValid low, except via alarmAck.
REQ-027 alarmActive, alarmIrq and alarmChannel SHALL be registered, valid in the cycle after the state transition that causes them.

Reset
REQ-028 While rstN is low, all FSMs SHALL be NORMAL, counters 0, and pressureAbnormality, alarmActive, alarmIrq, alarmChannel all 0.
REQ-029 Reset asserted mid-sequence SHALL discard all partial counts and latched alarms immediately, without waiting for clk.
REQ-030 First sample after rstN deasserts SHALL be treated as the first of any sequence.

Structure
REQ-031 FSM state encoding and default threshold/persistence constants SHALL live in shared package pressure_pkg.
REQ-032 Per-channel logic SHALL be sub-module pressure_channel_fsm, instantiated CHANNELS times via generate; top level does priority encoding and output registers.

Verification
REQ-033 Ch0 samples 5,5,5 with sampleValid -> pressureAbnormality[0]=1 after first; alarmActive[0]=1, alarmIrq=1, alarmChannel=0 after third.
REQ-034 Ch1 samples 60,60,30,60,60 -> no alarm; counter restarts after the 30 sample.
REQ-035 Ch2 samples 10 and 50 (thresholds) -> pressureAbnormality[2]=0, no SUSPECT entry.
REQ-036 Ch1 and ch3 in ALARM, alarmAck with ackChannel=1 -> alarmChannel=3, alarmActive[1]=1 stays; after two normal ch1 samples (30,30) -> alarmActive[1]=0.
REQ-037 alarmAck with ackChannel=2 while ch2 NORMAL -> no state change; ack coinciding with sample on ALARM channel -> ACKED, sample ignored.
REQ-038 rstN pulsed low between second and third abnormal sample on ch0 -> all outputs 0 immediately; three further abnormal samples required to alarm.

Source files
------------

// File: rtl/pressure_pkg.sv
// pressure_pkg: shared state encoding and default constants for the pressure alarm monitor.
// Revision 1.0
`default_nettype none

package pressure_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_ALARM   = 2'd2,
        ST_ACKED   = 2'd3
    } chan_state_t;

    localparam int DEF_CHANNELS    = 4;
    localparam int DEF_DATA_WIDTH  = 6;
    localparam int DEF_LOW_TH      = 10;
    localparam int DEF_HIGH_TH     = 50;
    localparam int DEF_PERSIST     = 3;
    localparam int DEF_CLEAR_COUNT = 2;
    localparam int CNT_WIDTH       = 4;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        return (value == {CNT_WIDTH{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pressure_channel_fsm.sv
// pressure_channel_fsm: per-channel NORMAL/SUSPECT/ALARM/ACKED tracker with saturating run counter.
// Revision 1.0
`default_nettype none

module pressure_channel_fsm
    import pressure_pkg::*;
#(
    parameter int PERSIST     = DEF_PERSIST,
    parameter int CLEAR_COUNT = DEF_CLEAR_COUNT
) (
    input  logic clk,
    input  logic rstN,
    input  logic sample_valid,
    input  logic abnormal,
    input  logic ack,
    output logic alarm_next,
    output logic active_next
);

    chan_state_t             state;
    chan_state_t             nxt_state;
    logic [CNT_WIDTH-1:0]    count;
    logic [CNT_WIDTH-1:0]    nxt_count;
    logic [CNT_WIDTH-1:0]    count_inc;

    assign count_inc = sat_inc(count);

    always_comb begin
        nxt_state = state;
        nxt_count = count;
        case (state)
            ST_NORMAL: begin
                if (sample_valid && abnormal) begin
                    if (PERSIST == 1) begin
                        nxt_state = ST_ALARM;
                        nxt_count = '0;
                    end else begin
                        nxt_state = ST_SUSPECT;
                        nxt_count = CNT_WIDTH'(1);
                    end
                end
            end
            ST_SUSPECT: begin
                if (sample_valid) begin
                    if (!abnormal) begin
                        nxt_state = ST_NORMAL;
                        nxt_count = '0;
                    end else if (count_inc >= CNT_WIDTH'(PERSIST)) begin
                        nxt_state = ST_ALARM;
                        nxt_count = '0;
                    end else begin
                        nxt_count = count_inc;
                    end
                end
            end
            // The acknowledge takes precedence; a coincident sample is dropped.
            ST_ALARM: begin
                if (ack) begin
                    nxt_state = ST_ACKED;
                    nxt_count = '0;
                end
            end
            ST_ACKED: begin
                if (sample_valid) begin
                    if (abnormal) begin
                        nxt_count = '0;
                    end else if (count_inc >= CNT_WIDTH'(CLEAR_COUNT)) begin
                        nxt_state = ST_NORMAL;
                        nxt_count = '0;
                    end else begin
                        nxt_count = count_inc;
                    end
                end
            end
            default: begin
                nxt_state = ST_NORMAL;
                nxt_count = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= ST_NORMAL;
            count <= '0;
        end else begin
            state <= nxt_state;
            count <= nxt_count;
        end
    end

    // Next-state flags let the top register its outputs in step with the state.
    assign alarm_next  = (nxt_state == ST_ALARM);
    assign active_next = (nxt_state == ST_ALARM) || (nxt_state == ST_ACKED);

endmodule

`default_nettype wire

// File: rtl/pressure_alarm_monitor.sv
// pressure_alarm_monitor: multi-channel threshold checker with persistence, acknowledge and priority IRQ.
// Revision 1.0
`default_nettype none

module pressure_alarm_monitor
    import pressure_pkg::*;
#(
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int LOW_TH      = DEF_LOW_TH,
    parameter int HIGH_TH     = DEF_HIGH_TH,
    parameter int PERSIST     = DEF_PERSIST,
    parameter int CLEAR_COUNT = DEF_CLEAR_COUNT,
    parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                           clk,
    input  logic                           rstN,
    input  logic [CHANNELS*DATA_WIDTH-1:0] pressureData,
    input  logic                           sampleValid,
    input  logic                           alarmAck,
    input  logic [CH_W-1:0]                ackChannel,
    output logic [CHANNELS-1:0]            pressureAbnormality,
    output logic [CHANNELS-1:0]            alarmActive,
    output logic                           alarmIrq,
    output logic [CH_W-1:0]                alarmChannel
);

    logic [CHANNELS-1:0] abnormal;
    logic [CHANNELS-1:0] alarm_next;
    logic [CHANNELS-1:0] active_next;
    logic [CH_W-1:0]     enc_channel;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_channel
        logic [DATA_WIDTH-1:0] sample;
        logic                  ack_hit;

        assign sample      = pressureData[k*DATA_WIDTH +: DATA_WIDTH];
        assign abnormal[k] = (32'(sample) < 32'(LOW_TH)) || (32'(sample) > 32'(HIGH_TH));
        assign ack_hit     = alarmAck && (32'(ackChannel) == 32'(k));

        pressure_channel_fsm #(
            .PERSIST     (PERSIST),
            .CLEAR_COUNT (CLEAR_COUNT)
        ) u_fsm (
            .clk          (clk),
            .rstN         (rstN),
            .sample_valid (sampleValid),
            .abnormal     (abnormal[k]),
            .ack          (ack_hit),
            .alarm_next   (alarm_next[k]),
            .active_next  (active_next[k])
        );
    end

    // Scan from the top so the lowest alarming index wins.
    always_comb begin
        enc_channel = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (alarm_next[k]) begin
                enc_channel = CH_W'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pressureAbnormality <= '0;
            alarmActive         <= '0;
            alarmIrq            <= 1'b0;
            alarmChannel        <= '0;
        end else begin
            if (sampleValid) begin
                pressureAbnormality <= abnormal;
            end
            alarmActive  <= active_next;
            alarmIrq     <= |alarm_next;
            alarmChannel <= enc_channel;
        end
    end

endmodule

`default_nettype wire
